disp_scan: RTL and testbench
============================

# disp_scan

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one `dec7seg` BCD/hex decoder among `NDIG` digits by cycling an active-low digit-select bus, and inserts dead time between digits to suppress ghosting. A load port double-buffers the displayed value so that updates take effect only at frame boundaries. It sits between the lab datapath (counters, ALU results) and the board's shared segment/anode pins.

## Interface
- `NDIG`, 4: number of digits scanned, range 2..8.
- `PRESCALE`, 50000: clock cycles per digit slot, must be at least `BLANK_CYCLES+1`.
- `BLANK_CYCLES`, 2: dead-time cycles at the start of each slot, with all anodes off. Must be at least 1.
- `clk_i` in 1: system clock; all logic on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `enable_i` in 1: scan enable. When low, the display is dark and the scan is held at its start.
- `value_i` in 4*NDIG: hex digits to show; digit 0 is in bits [3:0] and is the rightmost digit.
- `load_i` in 1: single-cycle strobe that captures `value_i`.
- `lzb_i` in 1: leading-zero blanking enable.
- `blank_i` in NDIG: per-digit force-blank mask, applied live (not buffered).
- `pending_o` out 1: high while a captured value has not yet been applied to the display.
- `seg_o` out 7: segment drive, active-low, bit order 6..0 = g..a (same order as `dec7seg`).
- `an_o` out NDIG: digit select, active-low, at most one bit low at any time.

## Operation
- **Registers.** Slot counter `cnt` (0..PRESCALE-1), digit index `idx` (0..NDIG-1), `shadow` and `disp` (each 4*NDIG), and `pending`.
- **Per-slot state.**
  - `cnt < BLANK_CYCLES`: state BLANK.
  - Otherwise: state SHOW.
  - At `cnt == PRESCALE-1`: `cnt` returns to 0 and `idx` advances, wrapping from NDIG-1 to 0.
- **BLANK output.** `an_o` all ones, `seg_o = 7'h7F`.
- **SHOW output.** `an_o` has bit `idx` low, and `seg_o` is the `dec7seg` output for `disp[idx]`. This is overridden to BLANK output when the digit is suppressed.
- **Digit suppression.** A digit is suppressed if either:
  - `blank_i[idx]` is set, or
  - `lzb_i` is set, `idx != 0`, and every digit of `disp` from `idx` up to NDIG-1 is zero.
  - Digit 0 is never suppressed by leading-zero blanking, so a value of 0 displays "0".
- **Load.**
  - `load_i` writes `value_i` into `shadow` and sets `pending`.
  - Back-to-back loads overwrite `shadow`; only the last one is applied.
- **Frame-boundary apply.**
  - When `idx` wraps to 0 and `pending` is set, `disp <= shadow` and `pending` clears.
  - If `load_i` arrives on the wrap cycle itself, `value_i` goes directly into `disp` and `shadow`, and `pending` stays 0.
- **Disabled.**
  - `cnt` and `idx` are forced to 0, and the outputs take the BLANK value.
  - A pending value is applied on the next cycle, because the frame boundary is trivial while disabled.
  - On re-enable, the scan starts at `cnt=0`, `idx=0`.
- **Widths.**
  - `cnt` is `$clog2(PRESCALE)` bits and `idx` is `$clog2(NDIG)` bits.
  - No arithmetic is needed beyond the increments.

## Timing
- **Reset values.**
  - `an_o` all ones, `seg_o = 7'h7F`, `pending_o = 0`.
  - `cnt = 0`, `idx = 0`, `shadow = 0`, `disp = 0`.
- **Output latency.**
  - `seg_o`/`an_o` are registered and reflect `cnt`/`idx`/`disp` from the previous cycle (1-cycle latency).
  - `pending_o` is the `pending` register itself.
- **Anode transitions.** The falling edge of any `an_o` bit is preceded by at least `BLANK_CYCLES` cycles with `an_o` all ones. Two anode bits are never low simultaneously, including across reset and enable toggles.
- **Frame period.** `NDIG*PRESCALE` cycles.
- **Worst-case load-to-display.**
  - A value reaches `disp` at most `NDIG*PRESCALE` cycles after `load_i`.
  - It reaches the pins one cycle after that.
- **Reset mid-slot.** Reset wins over all other inputs. On the next cycle the outputs are dark and any pending load is discarded.

## Structure
- Package `disp_pkg`:
  - `SEG_OFF = 7'h7F`.
  - `scan_state_t` enum {BLANK, SHOW}.
  - Function `lz_mask(disp, ndig)` returning the suppression vector.
- Instantiates the existing `dec7seg` once, driven by mux `disp[idx]`; this is the only sub-module.

## Test plan
All scenarios use `NDIG=4`, `PRESCALE=4`, `BLANK_CYCLES=1` (16-cycle frame).
- **Reset and first slot.** Reset, then hold `enable_i=1` with `disp=0`, `lzb_i=0`.
  - `an_o=4'hF` for 1 cycle after the first post-reset edge.
  - Then `an_o=4'hE` and `seg_o=7'h40` for 3 cycles.
  - Then blank for 1 cycle, then `an_o=4'hD`.
- **Frame-boundary apply.**
  - `load_i` with `value_i=16'h1234` mid-frame: `pending_o=1` until the `idx` wrap.
  - Next frame shows digits 4,3,2,1 on `an_o` E,D,B,7 with `seg_o` 19,30,24,79.
- **Leading-zero blanking.** `value_i=16'h0050`, `lzb_i=1`.
  - Digits 3 and 2 are dark (`an_o` stays F during those slots).
  - Digit 1 shows `7'h12`, digit 0 shows `7'h40`.
  - `value_i=0` shows only digit 0 = `7'h40`.
- **Load collisions.**
  - Loads of `16'hAAAA` then `16'hBBBB` within one frame: only B appears (`seg_o=7'h03`).
  - `load_i` on the wrap cycle: applied immediately and `pending_o` never rises.
- **Enable toggle and force-blank.**
  - Drop `enable_i` mid-SHOW: the next output is dark.
  - Re-enable: restart at `an_o=4'hF` then `4'hE`.
  - `blank_i=4'b0100`: the digit 2 slot stays dark.
- **Assertions throughout.**
  - `$countones(~an_o) <= 1` on every cycle.
  - No adjacent-digit handoff occurs without an all-ones cycle between.
  - Reset asserted mid-slot with a pending load gives dark outputs and `pending_o=0` on the next cycle.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types, constants and helpers for the multiplexed 7-segment scan controller.
package disp_pkg;

  localparam int unsigned MAX_DIG = 8;
  localparam logic [6:0]  SEG_OFF = 7'h7F;

  typedef enum logic [0:0] {BLANK, SHOW} scan_state_t;

  // Leading-zero suppression vector: bit i set when digits i..ndig-1 are all zero.
  // Digit 0 is never flagged so a zero value still shows a single "0".
  function automatic logic [MAX_DIG-1:0] lz_mask(input logic [4*MAX_DIG-1:0] disp,
                                                 input int unsigned ndig);
    logic [MAX_DIG-1:0] mask;
    logic               all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int unsigned i = MAX_DIG - 1; i >= 1; i--) begin
      if (i < ndig) begin
        all_zero = all_zero & (disp[i*4 +: 4] == 4'h0);
        mask[i]  = all_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/dec7seg.sv
// Hex to 7-segment decoder, active-low segments, bit order 6..0 = g..a.
module dec7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the glyph for each nibble
  always_comb begin
    case (hex_i)
      4'h0:    seg_o = 7'h40;
      4'h1:    seg_o = 7'h79;
      4'h2:    seg_o = 7'h24;
      4'h3:    seg_o = 7'h30;
      4'h4:    seg_o = 7'h19;
      4'h5:    seg_o = 7'h12;
      4'h6:    seg_o = 7'h02;
      4'h7:    seg_o = 7'h78;
      4'h8:    seg_o = 7'h00;
      4'h9:    seg_o = 7'h10;
      4'hA:    seg_o = 7'h08;
      4'hB:    seg_o = 7'h03;
      4'hC:    seg_o = 7'h46;
      4'hD:    seg_o = 7'h21;
      4'hE:    seg_o = 7'h06;
      default: seg_o = 7'h0E;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Each digit slot starts with dead time (all anodes off) to avoid ghosting; the shown
// value is double-buffered and swapped in only at frame boundaries.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned NDIG         = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [4*NDIG-1:0] value_i,
  input  logic              load_i,
  input  logic              lzb_i,
  input  logic [NDIG-1:0]   blank_i,
  output logic              pending_o,
  output logic [6:0]        seg_o,
  output logic [NDIG-1:0]   an_o
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*NDIG-1:0]   shadow_q, shadow_d;
  logic [4*NDIG-1:0]   disp_q, disp_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic [NDIG-1:0]     an_q, an_d;

  logic [4*MAX_DIG-1:0] disp_ext;
  logic [MAX_DIG-1:0]   lz_all;
  logic [3:0]           digit;
  logic                 suppress;
  logic [NDIG-1:0]      an_sel;
  logic [6:0]           seg_dec;
  logic                 wrap;
  scan_state_t          state;

  dec7seg u_dec7seg (
    .hex_i (digit),
    .seg_o (seg_dec)
  );

  // Select the current digit, its anode pattern and whether it is suppressed
  always_comb begin
    disp_ext               = '0;
    disp_ext[4*NDIG-1:0]   = disp_q;
    lz_all                 = lz_mask(disp_ext, NDIG);
    digit                  = 4'h0;
    suppress               = 1'b0;
    an_sel                 = '1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        digit     = disp_q[i*4 +: 4];
        suppress  = blank_i[i] | (lzb_i & lz_all[i]);
        an_sel[i] = 1'b0;
      end
    end
  end

  // Slot phase decode and next registered pin values (dark unless showing a live digit)
  always_comb begin
    state = (cnt_q < BLANK_END) ? BLANK : SHOW;
    an_d  = '1;
    seg_d = SEG_OFF;
    if (enable_i && (state == SHOW) && !suppress) begin
      an_d  = an_sel;
      seg_d = seg_dec;
    end
  end

  // Scan counters and double-buffer update; a disabled scan is a permanent frame boundary
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    wrap      = !enable_i || ((cnt_q == CNT_MAX) && (idx_q == IDX_MAX));

    if (!enable_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (load_i && wrap) begin
      // A load on the boundary itself bypasses the shadow wait
      shadow_d  = value_i;
      disp_d    = value_i;
      pending_d = 1'b0;
    end else if (load_i) begin
      shadow_d  = value_i;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      an_q      <= '1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg_o     = seg_q;
  assign an_o      = an_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with a 4-digit, 4-cycle-slot, 1-blank-cycle configuration.
module tb_disp_scan;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic        lzb;
  logic [3:0]  blank;
  logic        pending;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;  // frame position (idx*4+cnt) the DUT holds before the next edge
  int last_pos = 0;  // position the outputs currently reflect
  logic       mon_en = 1'b0;
  logic [3:0] prev_an = 4'hF;

  disp_scan #(
    .NDIG         (4),
    .PRESCALE     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .enable_i  (enable),
    .value_i   (value),
    .load_i    (load),
    .lzb_i     (lzb),
    .blank_i   (blank),
    .pending_o (pending),
    .seg_o     (seg),
    .an_o      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    last_pos = pos;
    pos = (rst || !enable) ? 0 : (pos + 1) % 16;
    #1;
  endtask

  task automatic step_to(input int p);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (last_pos != p && n < 40);
    if (last_pos != p) check("step_to timeout", last_pos, p);
  endtask

  // segs = {s3,s2,s1,s0}; dark marks digits expected to stay off
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dark);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int d = 0; d < 4; d++) begin
      step_to(d * 4);
      check({tag, " gap an"}, an, 4'hF);
      step_to(d * 4 + 1);
      exp_an  = dark[d] ? 4'hF : ~(4'b0001 << d);
      exp_seg = dark[d] ? 7'h7F : segs[d*7 +: 7];
      check($sformatf("%s d%0d an", tag, d), an, exp_an);
      check($sformatf("%s d%0d seg", tag, d), seg, exp_seg);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Anode safety monitor: never two digits on, never a direct digit-to-digit handoff
  always @(negedge clk) begin
    if (mon_en) begin
      check("onehot", ($countones(~an) <= 1), 1);
      if (prev_an != 4'hF && an != 4'hF) check("handoff", an, prev_an);
      prev_an = an;
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b1; value = '0; load = 1'b0; lzb = 1'b0; blank = '0;
    step(); step();
    mon_en = 1'b1;
    check("reset an", an, 4'hF);
    check("reset seg", seg, 7'h7F);
    check("reset pending", pending, 0);
    rst = 1'b0;

    // First slot timing after reset
    step();
    check("first gap an", an, 4'hF);
    for (int k = 0; k < 3; k++) begin
      step();
      check("first d0 an", an, 4'hE);
      check("first d0 seg", seg, 7'h40);
    end
    step();
    check("first gap2 an", an, 4'hF);
    step();
    check("first d1 an", an, 4'hD);

    // Mid-frame load waits for the frame boundary
    do_load(16'h1234);
    check("apply pend early", pending, 1);
    step_to(14);
    check("apply pend late", pending, 1);
    step_to(15);
    check("apply pend clr", pending, 0);
    check_frame("apply", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);

    // Leading-zero blanking
    lzb = 1'b1;
    do_load(16'h0050);
    step_to(15);
    check_frame("lzb", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1100);
    do_load(16'h0000);
    step_to(15);
    check_frame("zero", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110);

    // Two loads in one frame: last wins
    step_to(2);
    do_load(16'hAAAA);
    step_to(6);
    do_load(16'hBBBB);
    step_to(15);
    check_frame("collide", {7'h03, 7'h03, 7'h03, 7'h03}, 4'b0000);

    // Load exactly on the wrap edge goes straight to the display
    step_to(14);
    do_load(16'h5678);
    check("wrapload pend", pending, 0);
    check_frame("wrapload", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0000);

    // Live force-blank of digit 2
    blank = 4'b0100;
    step_to(15);
    check_frame("forceblank", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0100);
    blank = 4'b0000;

    // Enable toggle mid-SHOW
    step_to(2);
    check("pre-dis an", an, 4'hE);
    enable = 1'b0;
    step();
    check("dis an", an, 4'hF);
    check("dis seg", seg, 7'h7F);
    do_load(16'h9999);
    check("dis load pend", pending, 0);
    step();
    check("dis an2", an, 4'hF);
    enable = 1'b1;
    step();
    check("reen gap an", an, 4'hF);
    step();
    check("reen d0 an", an, 4'hE);
    check("reen d0 seg", seg, 7'h10);

    // Reset mid-slot discards a pending load
    step_to(5);
    do_load(16'h1111);
    check("rst pend set", pending, 1);
    rst = 1'b1;
    step();
    check("rst an", an, 4'hF);
    check("rst seg", seg, 7'h7F);
    check("rst pending", pending, 0);
    rst = 1'b0;
    step();
    check("post-rst gap an", an, 4'hF);
    step();
    check("post-rst d0 an", an, 4'hE);
    check("post-rst d0 seg", seg, 7'h40);
    step_to(5);
    check("post-rst d1 dark", an, 4'hF);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run cannot hang
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
